// File: rtl/objram_dma_pkg.sv
// objram_dma_pkg
// Shared definitions for the object RAM DMA block: copy-window defaults
// and the transfer FSM state encoding.
//   DEF_WORDS  : 16-bit object words copied per DMA window
//   DEF_AW     : object RAM address width (DEF_WORDS <= 2**DEF_AW)
//   dma_state_t: IDLE -> REQ -> COPY -> DRAIN -> IDLE
package objram_dma_pkg;

   localparam int DEF_WORDS = 1024;
   localparam int DEF_AW    = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_COPY  = 2'd2,
      ST_DRAIN = 2'd3
   } dma_state_t;

endpackage

// File: rtl/objram_dma_addrgen.sv
// objram_dma_addrgen
// Source read counter plus the one-enabled-cycle write pipeline.
//   clk, rst_n : master clock, async active-low reset
//   en         : pixel clock enable (active-high here); nothing moves without it
//   clear      : restart the counter at address 0 (start of a window)
//   rd         : a read is issued at src_addr on this enabled cycle
//   src_addr   : current source read address
//   last       : src_addr is the final word of the window
//   wr_addr    : source address of the word now arriving on the data bus
//   wr_pending : a read was issued on the previous enabled cycle, so its
//                data is due to be written on this one
module objram_dma_addrgen
   import objram_dma_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int AW    = DEF_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clear,
   input  logic          rd,
   output logic [AW-1:0] src_addr,
   output logic          last,
   output logic [AW-1:0] wr_addr,
   output logic          wr_pending
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

   logic [AW-1:0] cnt_q;

   // The counter saturates at the final word: it is never allowed to
   // step past WORDS-1, even if a read were requested there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         wr_addr    <= '0;
         wr_pending <= 1'b0;
      end else if (en) begin
         wr_pending <= rd;
         if (rd) begin
            wr_addr <= cnt_q;
         end
         if (clear) begin
            cnt_q <= '0;
         end else if (rd && (cnt_q != LAST_ADDR)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign src_addr = cnt_q;
   assign last     = (cnt_q == LAST_ADDR);

endmodule

// File: rtl/objram_dma.sv
// objram_dma
// Copies WORDS 16-bit words from object RAM into one bank of a double
// buffered shadow RAM during each DMA window of the video timing generator.
// Ports:
//   i_EMU_MCLK, i_MRST_n   : master clock, async active-low reset
//   i_EMU_CLK6MPCEN_n      : active-low clock enable; every state change and
//                            every strobe is confined to enabled cycles
//   i_DMA_n, i_FRAMEPARITY : DMA window (falling edge starts a copy), parity
//                            picking the shadow bank (bank = ~parity)
//   o_CPU_HOLD/i_CPU_HOLDACK : bus request / level grant
//   o_SRC_ADDR/o_SRC_RD/i_SRC_DATA : object RAM read port (1-cycle latency)
//   o_DST_ADDR/o_DST_DATA/o_DST_WR : shadow RAM write port, MSB = bank
//   o_BUSY, o_DONE, o_ABORT : status (busy level, done pulse, sticky abort)
//   o_DBG_STATE            : current FSM state for observation
//
// Bus handshake: o_CPU_HOLD is a request held high for as long as this
// block owns object RAM (REQ, COPY, DRAIN); i_CPU_HOLDACK is the level grant.
// Copying starts on the first enabled cycle that sees the grant and runs
// only while it stays high; a grant that drops during COPY, or a window that
// closes (i_DMA_n rising) in REQ or COPY, ends the transfer as an abort.
module objram_dma
   import objram_dma_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int AW    = DEF_AW
) (
   input  logic          i_EMU_MCLK,
   input  logic          i_MRST_n,
   input  logic          i_EMU_CLK6MPCEN_n,
   input  logic          i_DMA_n,
   input  logic          i_FRAMEPARITY,
   output logic          o_CPU_HOLD,
   input  logic          i_CPU_HOLDACK,
   output logic [AW-1:0] o_SRC_ADDR,
   output logic          o_SRC_RD,
   input  logic [15:0]   i_SRC_DATA,
   output logic [AW:0]   o_DST_ADDR,
   output logic [15:0]   o_DST_DATA,
   output logic          o_DST_WR,
   output logic          o_BUSY,
   output logic          o_DONE,
   output logic          o_ABORT,
   output dma_state_t    o_DBG_STATE
);

   dma_state_t    state_q, state_d;
   logic          en;
   logic          dma_q;
   logic          bank_q;
   logic          abort_q;
   logic          dma_fall, dma_rise;
   logic          start, set_abort, rd, done;
   logic          last, wr_pending, wr;
   logic [AW-1:0] src_addr, wr_addr;

   assign en = ~i_EMU_CLK6MPCEN_n;

   // Edges of i_DMA_n are taken against the copy registered on the last
   // enabled cycle, so an edge during a disabled stretch is still seen.
   assign dma_fall = dma_q & ~i_DMA_n;
   assign dma_rise = ~dma_q & i_DMA_n;

   always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
         state_q <= ST_IDLE;
         dma_q   <= 1'b1;
         bank_q  <= 1'b0;
         abort_q <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         dma_q   <= i_DMA_n;
         if (start) begin
            bank_q  <= ~i_FRAMEPARITY;
            abort_q <= 1'b0;
         end else if (set_abort) begin
            abort_q <= 1'b1;
         end
      end
   end

   // All strobes produced here already include en, so they can never be
   // high on a disabled cycle.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      set_abort = 1'b0;
      rd        = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && dma_fall) begin
               state_d = ST_REQ;
               start   = 1'b1;
            end
         end
         ST_REQ: begin
            if (en) begin
               if (dma_rise) begin
                  state_d   = ST_IDLE;
                  set_abort = 1'b1;
               end else if (i_CPU_HOLDACK) begin
                  state_d = ST_COPY;
               end
            end
         end
         ST_COPY: begin
            if (en) begin
               if (dma_rise || !i_CPU_HOLDACK) begin
                  // No new read; the write already in flight still lands
                  // this cycle through wr_pending.
                  state_d   = ST_IDLE;
                  set_abort = 1'b1;
               end else begin
                  rd = 1'b1;
                  if (last) begin
                     state_d = ST_DRAIN;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (en) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   objram_dma_addrgen #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_addrgen (
      .clk        (i_EMU_MCLK),
      .rst_n      (i_MRST_n),
      .en         (en),
      .clear      (start),
      .rd         (rd),
      .src_addr   (src_addr),
      .last       (last),
      .wr_addr    (wr_addr),
      .wr_pending (wr_pending)
   );

   assign wr = wr_pending & en;

   assign o_CPU_HOLD  = (state_q != ST_IDLE);
   assign o_BUSY      = (state_q != ST_IDLE);
   assign o_SRC_ADDR  = src_addr;
   assign o_SRC_RD    = rd;
   assign o_DST_ADDR  = {bank_q, wr_addr};
   // Data bus is forced to zero outside write strobes so reset leaves it 0.
   assign o_DST_DATA  = wr ? i_SRC_DATA : 16'h0000;
   assign o_DST_WR    = wr;
   assign o_DONE      = done;
   assign o_ABORT     = abort_q;
   assign o_DBG_STATE = state_q;

endmodule

// File: tb/tb_objram_dma.sv
// tb_objram_dma
// Bench for objram_dma: a source RAM model, directed scenarios (nominal,
// enable gaps, window abort, grant drop, parity banks, mid-copy reset) and
// a per-cycle monitor that scores every read and write against queues of
// expected transfers built from the copy rules.
module tb_objram_dma;
   import objram_dma_pkg::*;

   localparam int WORDS = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cen_n;
   logic          dma_n;
   logic          parity;
   logic          ack;
   logic [15:0]   src_data;
   logic          o_CPU_HOLD;
   logic [AW-1:0] o_SRC_ADDR;
   logic          o_SRC_RD;
   logic [AW:0]   o_DST_ADDR;
   logic [15:0]   o_DST_DATA;
   logic          o_DST_WR;
   logic          o_BUSY;
   logic          o_DONE;
   logic          o_ABORT;
   dma_state_t    o_DBG_STATE;

   objram_dma dut (
      .i_EMU_MCLK        (clk),
      .i_MRST_n          (rst_n),
      .i_EMU_CLK6MPCEN_n (cen_n),
      .i_DMA_n           (dma_n),
      .i_FRAMEPARITY     (parity),
      .o_CPU_HOLD        (o_CPU_HOLD),
      .i_CPU_HOLDACK     (ack),
      .o_SRC_ADDR        (o_SRC_ADDR),
      .o_SRC_RD          (o_SRC_RD),
      .i_SRC_DATA        (src_data),
      .o_DST_ADDR        (o_DST_ADDR),
      .o_DST_DATA        (o_DST_DATA),
      .o_DST_WR          (o_DST_WR),
      .o_BUSY            (o_BUSY),
      .o_DONE            (o_DONE),
      .o_ABORT           (o_ABORT),
      .o_DBG_STATE       (o_DBG_STATE)
   );

   // ---------------- clock / enable / source RAM ----------------
   always #5 clk = ~clk;

   logic [15:0]   mem [WORDS];
   int            gap = 1;
   int            ph = 0;
   logic          rd_seen;
   logic [AW-1:0] rd_a;

   // Enable pattern and source RAM: a read seen in an enabled cycle puts
   // its word on the bus from the next edge until the next read.
   initial begin
      cen_n    = 1'b0;
      src_data = 16'h0000;
      forever begin
         @(negedge clk);
         rd_seen = o_SRC_RD;
         rd_a    = o_SRC_ADDR;
         @(posedge clk);
         #1;
         if (rd_seen) src_data = mem[rd_a];
         ph    = (ph + 1) % gap;
         cen_n = (ph != 0);
      end
   end

   // ---------------- scoreboard ----------------
   int            n_checks = 0;
   int            n_fail = 0;
   int            en_cnt = 0;
   int            n_rd = 0;
   int            n_wr = 0;
   int            n_done = 0;
   int            grant_en = 0;
   bit            grant_seen = 1'b0;
   logic [AW:0]   first_wr, last_wr;
   logic [AW-1:0] exp_rd [$];
   logic [AW+16:0] exp_wr [$];
   logic [AW+16:0] w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cen_n) begin
         chk("strobe_gated", 32'({o_SRC_RD, o_DST_WR, o_DONE}), 32'd0);
      end else begin
         en_cnt++;
         if (o_SRC_RD) begin
            n_rd++;
            if (exp_rd.size() == 0) chk("rd_extra", 32'(o_SRC_ADDR), 32'hFFFF_FFFF);
            else chk("rd_addr", 32'(o_SRC_ADDR), 32'(exp_rd.pop_front()));
         end
         if (o_DST_WR) begin
            n_wr++;
            if (n_wr == 1) first_wr = o_DST_ADDR;
            last_wr = o_DST_ADDR;
            if (exp_wr.size() == 0) begin
               chk("wr_extra", 32'(o_DST_ADDR), 32'hFFFF_FFFF);
            end else begin
               w = exp_wr.pop_front();
               chk("wr_addr", 32'(o_DST_ADDR), 32'(w[AW+16:16]));
               chk("wr_data", 32'(o_DST_DATA), 32'(w[15:0]));
            end
         end
         if (o_DONE) begin
            n_done++;
            if (grant_seen) chk("done_latency", 32'(en_cnt - grant_en), 32'(WORDS + 1));
         end
         if (!grant_seen && o_CPU_HOLD && ack) begin
            grant_seen = 1'b1;
            grant_en   = en_cnt;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_en(input int n);
      int e0;
      e0 = en_cnt;
      while (en_cnt < e0 + n) step();
   endtask

   task automatic expect_words(input bit par, input int n);
      exp_rd.delete();
      exp_wr.delete();
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(AW'(i));
         exp_wr.push_back({~par, AW'(i), mem[i]});
      end
      n_rd = 0;
      n_wr = 0;
      n_done = 0;
      grant_seen = 1'b0;
   endtask

   task automatic open_window(input bit par);
      int t;
      parity = par;
      dma_n  = 1'b0;
      t = 0;
      while (!o_CPU_HOLD && t < 50) begin step(); t++; end
      chk("hold_rise_in_time", 32'(t < 50), 32'd1);
      chk("abort_cleared_at_start", 32'(o_ABORT), 32'd0);
      chk("busy_at_start", 32'(o_BUSY), 32'd1);
   endtask

   task automatic run_copy(input bit par, input logic [AW:0] lit_first, input logic [AW:0] lit_last);
      int t;
      expect_words(par, WORDS);
      open_window(par);
      wait_en(3);
      ack = 1'b1;
      t = 0;
      while (n_done == 0 && t < (WORDS + 20) * gap) begin step(); t++; end
      chk("done_in_time", 32'(n_done > 0), 32'd1);
      wait_en(2);
      chk("done_pulses", 32'(n_done), 32'd1);
      chk("rd_total", 32'(n_rd), 32'(WORDS));
      chk("wr_total", 32'(n_wr), 32'(WORDS));
      chk("wr_left", 32'(exp_wr.size()), 32'd0);
      chk("first_dst", 32'(first_wr), 32'(lit_first));
      chk("last_dst", 32'(last_wr), 32'(lit_last));
      chk("hold_released", 32'(o_CPU_HOLD), 32'd0);
      chk("busy_cleared", 32'(o_BUSY), 32'd0);
      chk("no_abort", 32'(o_ABORT), 32'd0);
      dma_n = 1'b1;
      ack   = 1'b0;
      wait_en(3);
   endtask

   task automatic run_abort(input bit by_ack, input int n, input logic [AW:0] lit_last);
      int t;
      expect_words(1'b1, n);
      open_window(1'b1);
      ack = 1'b1;
      t = 0;
      while (n_rd < n && t < n + 50) begin step(); t++; end
      chk("abort_reads_in_time", 32'(t < n + 50), 32'd1);
      if (by_ack) ack = 1'b0;
      else dma_n = 1'b1;
      step();
      @(negedge clk);
      chk("abort_hold_dropped", 32'(o_CPU_HOLD), 32'd0);
      chk("abort_busy_dropped", 32'(o_BUSY), 32'd0);
      chk("abort_flag", 32'(o_ABORT), 32'd1);
      step();
      wait_en(4);
      chk("abort_rd_total", 32'(n_rd), 32'(n));
      chk("abort_wr_total", 32'(n_wr), 32'(n));
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_wr_left", 32'(exp_wr.size()), 32'd0);
      chk("abort_first_dst", 32'(first_wr), 32'h000);
      chk("abort_last_dst", 32'(last_wr), 32'(lit_last));
      chk("abort_sticky", 32'(o_ABORT), 32'd1);
      dma_n = 1'b1;
      ack   = 1'b0;
      wait_en(3);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_hold"}, 32'(o_CPU_HOLD), 32'd0);
      chk({tag, "_src_rd"}, 32'(o_SRC_RD), 32'd0);
      chk({tag, "_dst_wr"}, 32'(o_DST_WR), 32'd0);
      chk({tag, "_busy"}, 32'(o_BUSY), 32'd0);
      chk({tag, "_done"}, 32'(o_DONE), 32'd0);
      chk({tag, "_abort"}, 32'(o_ABORT), 32'd0);
      chk({tag, "_src_addr"}, 32'(o_SRC_ADDR), 32'd0);
      chk({tag, "_dst_addr"}, 32'(o_DST_ADDR), 32'd0);
      chk({tag, "_dst_data"}, 32'(o_DST_DATA), 32'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int t;
      for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom_range(0, 65535));
      rst_n  = 1'b0;
      dma_n  = 1'b1;
      parity = 1'b0;
      ack    = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      wait_en(3);

      // nominal: parity 0 -> bank 1 -> dst 0x400..0x7FF
      run_copy(1'b0, 11'h400, 11'h7FF);

      // enable only every 4th master clock
      gap = 4;
      wait_en(2);
      run_copy(1'b0, 11'h400, 11'h7FF);
      gap = 1;
      wait_en(2);

      // window closes after 100 reads, then grant drops after 250 reads
      run_abort(1'b0, 100, 11'd99);
      run_abort(1'b1, 250, 11'd249);

      // consecutive frames: parity 0 then 1 -> bank 1 then 0
      run_copy(1'b0, 11'h400, 11'h7FF);
      run_copy(1'b1, 11'h000, 11'h3FF);

      // reset at word 500
      expect_words(1'b0, WORDS);
      open_window(1'b0);
      ack = 1'b1;
      t = 0;
      while (n_rd < 500 && t < 600) begin step(); t++; end
      chk("reset_reads_in_time", 32'(t < 600), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      dma_n = 1'b1;
      ack   = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      wait_en(3);
      rst_n = 1'b1;
      n_rd = 0;
      n_wr = 0;
      wait_en(6);
      chk("no_wr_after_reset", 32'(n_wr), 32'd0);
      chk("no_rd_after_reset", 32'(n_rd), 32'd0);
      run_copy(1'b0, 11'h400, 11'h7FF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
